boot_loader: RTL and testbench
==============================

Name: boot_loader

Overview:
- Upstream program/data loader for RISCV_Pipeline; replaces hierarchical bench preloads of instr_mem/data_mem.
- Accepts a 32-bit word stream over a valid/ready handshake and decodes segment headers.
- Writes payload words into instruction or data memory through registered write ports.
- Holds the core in reset until a terminator word arrives, then releases it.

Parameters:
IMEM_DEPTH, 64, instruction memory depth in 32-bit words
DMEM_DEPTH, 64, data memory depth in 32-bit words
ADDR_W, 6, memory word-address width; clog2 of the larger depth

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
in_valid  in  1  stream word valid
in_data  in  32  stream word
in_ready  out  1  loader can accept a word
imem_we  out  1  instruction memory write strobe
imem_addr  out  ADDR_W  instruction word address
imem_wdata  out  32  instruction word
dmem_we  out  1  data memory write strobe
dmem_addr  out  ADDR_W  data word address
dmem_wdata  out  32  data word
core_reset  out  1  reset to RISCV_Pipeline, active-high
done  out  1  load complete, sticky until reset
error  out  1  out-of-range segment seen, sticky until reset

Behaviour:
- Transfer rule: a word is accepted on a posedge where in_valid and in_ready are both 1.
- in_ready is combinational: 1 in HDR, ADDR and DATA; 0 in DONE.
- Reset values:
  - state=HDR.
  - imem_we=dmem_we=0; addresses and wdata=0.
  - core_reset=1, done=0, error=0.
  - Internal count=0, target=0, skip=0.
- Header word (HDR state):
  - Exactly 32'hFFFF_FFFF is the terminator. Otherwise:
  - bit31 = target (0 = imem, 1 = dmem).
  - bits30:16 are reserved and ignored.
  - bits15:0 = N, the payload word count.
- FSM transitions:
  - HDR, terminator accepted -> DONE.
  - HDR, other header accepted -> latch target and N -> ADDR.
  - ADDR, word accepted:
    - Latch base = in_data[15:0].
    - Range check: base+N > target depth, computed at 17 bits with no wrap. If it fails, set error=1 and skip=1.
    - N==0 -> HDR; else -> DATA.
  - DATA, word accepted:
    - If skip=0, write the word at the current address.
    - Then increment the address and decrement count.
    - Count reaching 0 -> HDR and clear skip.
  - DONE: terminal. Ignores all input until reset.
- Write timing:
  - Strobes, address and wdata are registered.
  - A DATA word accepted at edge k drives {imem|dmem}_we=1 with its address/data during cycle k..k+1; memory captures it at edge k+1.
  - Strobes are 1-cycle pulses; only one of imem_we/dmem_we is active at a time.
  - in_valid gaps insert idle cycles; the strobe stays 0 when no word was accepted.
- core_reset / done:
  - Both change on the same edge that enters DONE: core_reset 1->0, done 0->1.
  - The earliest terminator follows the last payload write by one edge, so the final write always lands before the core leaves reset.
- Skipped segment: payload words are still accepted (in_ready=1) and counted, but no strobes are issued.
- Address arithmetic: the word address increments by 1 per word and is truncated to ADDR_W bits. No wrap can occur in a non-skipped segment, because of the range check.
- Reset mid-operation: returns to HDR and reasserts core_reset=1 on the next edge. Any partial segment is abandoned; memory contents already written are not cleared.
- Back-to-back: full throughput, one word per cycle with in_valid held at 1.

Test Plan:
- Imem load: header 32'h0000_002B, addr 0, 43 instruction words, terminator.
  -> 43 imem_we pulses at addresses 0..42 with matching data.
  -> core_reset falls on the edge entering DONE; done=1; error=0.
- Dmem load: header 32'h8000_0004, addr 0, words 42,17,93,58, terminator.
  -> dmem_we at addresses 0..3 with exactly those values.
  -> imem_we never asserted.
- Out of range: header 32'h8000_0005, addr 62 (DMEM_DEPTH=64), 5 words.
  -> error=1 after the ADDR word; all 5 words accepted; zero dmem_we pulses.
  -> A following valid segment still writes correctly.
- Zero count and gaps:
  - Header 32'h0000_0000, addr 7 -> back in HDR with no strobes.
  - Then a 2-word imem segment with in_valid low for 3 cycles between words -> exactly 2 strobes, timed one edge after each accept.
- Reset mid-segment: assert reset after 2 of 4 DATA words.
  -> core_reset=1, state HDR, done=0.
  -> A fresh full load then completes normally.
- DONE lockout: after the terminator, drive in_valid=1 with 10 words.
  -> in_ready=0 and no strobes.
  -> done stays 1 and core_reset stays 0.

Source files
------------

// File: rtl/boot_loader.sv
// boot_loader: streams a program/data image into instruction or data memory
// over a valid/ready word interface, then releases the core from reset.
//
// Ports:
//   clock, reset          system clock; synchronous active-high reset
//   in_valid/in_ready     word handshake; a word moves when both are 1
//   in_data               stream word (header, base address, payload, terminator)
//   imem_we/addr/wdata    registered instruction-memory write port
//   dmem_we/addr/wdata    registered data-memory write port
//   core_reset            held high until the terminator word is accepted
//   done                  load complete, sticky until reset
//   error                 out-of-range segment seen, sticky until reset
//
// Stream format: header {target, reserved[14:0], N[15:0]}, then base address
// word (bits 15:0), then N payload words. 32'hFFFF_FFFF ends the load.
module boot_loader #(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter int unsigned DMEM_DEPTH = 64,
  parameter int unsigned ADDR_W     = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic              core_reset,
  output logic              done,
  output logic              error
);

  typedef enum logic [1:0] {S_HDR, S_ADDR, S_DATA, S_DONE} state_t;

  state_t              state_q;
  logic                target_q;
  logic [15:0]         count_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                skip_q;
  logic                imem_we_q, dmem_we_q;
  logic [ADDR_W-1:0]   imem_addr_q, dmem_addr_q;
  logic [31:0]         imem_wdata_q, dmem_wdata_q;
  logic                core_reset_q, done_q, error_q;

  logic                accept;
  logic [16:0]         depth_d;
  logic [16:0]         end_d;
  logic                range_fail_d;

  assign in_ready = (state_q != S_DONE);
  assign accept   = in_valid && in_ready;

  // Range check at 17 bits so base+N can never wrap past the depth.
  always_comb begin
    depth_d      = target_q ? 17'(DMEM_DEPTH) : 17'(IMEM_DEPTH);
    end_d        = {1'b0, in_data[15:0]} + {1'b0, count_q};
    range_fail_d = (end_d > depth_d);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_HDR;
      target_q     <= 1'b0;
      count_q      <= '0;
      addr_q       <= '0;
      skip_q       <= 1'b0;
      imem_we_q    <= 1'b0;
      dmem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      dmem_addr_q  <= '0;
      imem_wdata_q <= '0;
      dmem_wdata_q <= '0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      imem_we_q <= 1'b0;
      dmem_we_q <= 1'b0;
      if (accept) begin
        case (state_q)
          S_HDR: begin
            if (in_data == 32'hFFFF_FFFF) begin
              state_q      <= S_DONE;
              core_reset_q <= 1'b0;
              done_q       <= 1'b1;
            end else begin
              target_q <= in_data[31];
              count_q  <= in_data[15:0];
              state_q  <= S_ADDR;
            end
          end
          S_ADDR: begin
            addr_q <= in_data[ADDR_W-1:0];
            if (range_fail_d) error_q <= 1'b1;
            // An empty segment goes straight back to HDR, so skip must not
            // linger into the next segment.
            skip_q  <= range_fail_d && (count_q != '0);
            state_q <= (count_q == '0) ? S_HDR : S_DATA;
          end
          S_DATA: begin
            if (!skip_q) begin
              if (target_q) begin
                dmem_we_q    <= 1'b1;
                dmem_addr_q  <= addr_q;
                dmem_wdata_q <= in_data;
              end else begin
                imem_we_q    <= 1'b1;
                imem_addr_q  <= addr_q;
                imem_wdata_q <= in_data;
              end
            end
            addr_q  <= addr_q + 1'b1;
            count_q <= count_q - 16'd1;
            if (count_q == 16'd1) begin
              state_q <= S_HDR;
              skip_q  <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign core_reset = core_reset_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: builds the word stream from segment descriptions and
// predicts every strobe, address, data word and flag from those descriptions.
module tb_boot_loader;

  localparam int unsigned AW    = 6;
  localparam int unsigned DEPTH = 64;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [31:0]   in_data;
  logic          in_ready;
  logic          imem_we, dmem_we;
  logic [AW-1:0] imem_addr, dmem_addr;
  logic [31:0]   imem_wdata, dmem_wdata;
  logic          core_reset, done, error;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [31:0] pay [64];
  logic [31:0] exp_imem [DEPTH];
  logic [31:0] exp_dmem [DEPTH];
  bit          exp_iv [DEPTH];
  bit          exp_dv [DEPTH];
  logic [31:0] obs_imem [DEPTH];
  logic [31:0] obs_dmem [DEPTH];
  bit          err_exp;

  boot_loader #(.IMEM_DEPTH(64), .DMEM_DEPTH(64), .ADDR_W(AW)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .core_reset(core_reset), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  // Memory image as a real memory would capture it.
  always @(posedge clock) begin
    if (imem_we) obs_imem[imem_addr] <= imem_wdata;
    if (dmem_we) obs_dmem[dmem_addr] <= dmem_wdata;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] d);
    chk("ready_before_accept", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_data  = $urandom;
    @(posedge clock); #1;
    chk("idle_no_strobe", 64'({imem_we, dmem_we}), 64'd0);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clock); #1;
    reset   = 1'b0;
    err_exp = 1'b0;
    chk("rst_core_reset", 64'(core_reset), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_strobes", 64'({imem_we, dmem_we}), 64'd0);
    chk("rst_addrs", 64'({imem_addr, dmem_addr}), 64'd0);
    chk("rst_wdata", {imem_wdata, dmem_wdata}, 64'd0);
  endtask

  // One segment: header, base word, then up to 'stop' of its n payload words.
  // gap < 0 picks a random 0..2 idle cycles before each later payload word.
  task automatic load_seg(input bit tgt, input int unsigned n, input int unsigned base,
                          input int unsigned stop, input int gap, input bit rres);
    logic [31:0] hdr, aw;
    bit          oor;
    int unsigned g;
    logic [AW-1:0] a;
    hdr = {tgt, (rres ? 15'($urandom) : 15'd0), 16'(n)};
    send(hdr);
    chk("hdr_no_strobe", 64'({imem_we, dmem_we}), 64'd0);
    aw  = {(rres ? 16'($urandom) : 16'd0), 16'(base)};
    oor = (base + n > DEPTH);
    if (oor) err_exp = 1'b1;
    send(aw);
    chk("addr_error_flag", 64'(error), 64'(err_exp));
    chk("addr_no_strobe", 64'({imem_we, dmem_we}), 64'd0);
    for (int unsigned i = 0; i < n && i < stop; i++) begin
      if (i > 0) begin
        g = (gap < 0) ? $urandom_range(0, 2) : int'(gap);
        repeat (g) idle();
      end
      send(pay[i]);
      a = AW'(base + i);
      if (oor) begin
        chk("skip_no_strobe", 64'({imem_we, dmem_we}), 64'd0);
      end else if (tgt) begin
        chk("dmem_strobe", 64'({imem_we, dmem_we}), 64'b01);
        chk("dmem_addr", 64'(dmem_addr), 64'(a));
        chk("dmem_wdata", 64'(dmem_wdata), 64'(pay[i]));
        exp_dmem[a] = pay[i];
        exp_dv[a]   = 1'b1;
      end else begin
        chk("imem_strobe", 64'({imem_we, dmem_we}), 64'b10);
        chk("imem_addr", 64'(imem_addr), 64'(a));
        chk("imem_wdata", 64'(imem_wdata), 64'(pay[i]));
        exp_imem[a] = pay[i];
        exp_iv[a]   = 1'b1;
      end
    end
  endtask

  task automatic terminate();
    chk("pre_term_core_reset", 64'(core_reset), 64'd1);
    chk("pre_term_done", 64'(done), 64'd0);
    send(32'hFFFF_FFFF);
    chk("term_core_reset", 64'(core_reset), 64'd0);
    chk("term_done", 64'(done), 64'd1);
    chk("term_error", 64'(error), 64'(err_exp));
    chk("term_ready", 64'(in_ready), 64'd0);
    chk("term_no_strobe", 64'({imem_we, dmem_we}), 64'd0);
    for (int unsigned a = 0; a < DEPTH; a++) begin
      if (exp_iv[a]) chk("imem_image", 64'(obs_imem[a]), 64'(exp_imem[a]));
      if (exp_dv[a]) chk("dmem_image", 64'(obs_dmem[a]), 64'(exp_dmem[a]));
    end
  endtask

  task automatic fill_random(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) pay[i] = $urandom;
  endtask

  initial begin
    int unsigned n, base;
    bit tgt;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    err_exp  = 1'b0;
    for (int unsigned a = 0; a < DEPTH; a++) begin
      exp_iv[a] = 1'b0;
      exp_dv[a] = 1'b0;
    end
    @(posedge clock); #1;
    do_reset();

    // Imem load of 43 words.
    fill_random(43);
    load_seg(1'b0, 43, 0, 43, 0, 1'b0);
    terminate();

    // Dmem load with fixed values.
    do_reset();
    pay[0] = 32'd42; pay[1] = 32'd17; pay[2] = 32'd93; pay[3] = 32'd58;
    load_seg(1'b1, 4, 0, 4, 0, 1'b0);
    terminate();

    // Out-of-range segment, then a valid one.
    do_reset();
    fill_random(5);
    load_seg(1'b1, 5, 62, 5, 0, 1'b0);
    fill_random(3);
    load_seg(1'b1, 3, 10, 3, 0, 1'b0);
    terminate();

    // Zero count, then a gapped 2-word imem segment.
    do_reset();
    load_seg(1'b0, 0, 7, 0, 0, 1'b0);
    fill_random(2);
    load_seg(1'b0, 2, 20, 2, 3, 1'b0);
    terminate();

    // Reset mid-segment, then a fresh full load.
    do_reset();
    fill_random(4);
    load_seg(1'b0, 4, 30, 2, 0, 1'b0);
    do_reset();
    fill_random(6);
    load_seg(1'b0, 6, 0, 6, 0, 1'b0);
    terminate();

    // DONE lockout.
    for (int unsigned i = 0; i < 10; i++) begin
      chk("lock_ready", 64'(in_ready), 64'd0);
      in_valid = 1'b1;
      in_data  = $urandom;
      @(posedge clock); #1;
      chk("lock_no_strobe", 64'({imem_we, dmem_we}), 64'd0);
      chk("lock_flags", 64'({done, core_reset}), 64'b10);
    end
    in_valid = 1'b0;

    // Randomized segments with random gaps and occasional out-of-range bases.
    do_reset();
    for (int unsigned s = 0; s < 8; s++) begin
      tgt = 1'($urandom);
      n   = $urandom_range(1, 8);
      if ($urandom_range(0, 3) == 0) base = DEPTH - n + $urandom_range(1, 40000);
      else                            base = $urandom_range(0, DEPTH - n);
      fill_random(n);
      load_seg(tgt, n, base, n, -1, 1'b1);
      if ($urandom_range(0, 1) == 1) idle();
    end
    terminate();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
